dft_out_reorder: RTL and testbench
==================================

Name: dft_out_reorder

Overview:
- Output-side reader for the mixed-radix DFT core (2^a·3^b·5^c points, up to 2048) in the PUSCH transform-precoding chain.
- The core emits results in digit-reversed order on a sample strobe plus write address.
- This block captures one symbol into a RAM at the supplied addresses, then streams it out in natural order 0..N-1 over a valid/ready interface.
- It sits between the DFT core's do_re/do_im/do_en/address outputs and the resource-element mapper.

Parameters:
- WIDTH, 18, bit width of each real/imag component.
- AW, 11, address width; RAM depth is 2^AW.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; arms capture of a new symbol
- last_address  in  AW  N-1 for the symbol; sampled on start
- di_en  in  1  sample strobe from the DFT core
- di_addr  in  AW  digit-reversed write address for di_re/di_im
- di_re  in  WIDTH  real part of the DFT output
- di_im  in  WIDTH  imag part of the DFT output
- do_re  out  WIDTH  natural-order real part
- do_im  out  WIDTH  natural-order imag part
- do_valid  out  1  do_* holds a valid sample
- do_ready  in  1  downstream accepts the sample when do_valid && do_ready
- do_index  out  AW  natural index of the current do_* sample
- do_last  out  1  high with index N-1
- busy  out  1  high in FILL or DRAIN
- err  out  1  sticky error; cleared by start

Behaviour:
- Reset (async, rst_n=0): state IDLE. do_valid, do_last, busy and err are 0. do_re, do_im and do_index are 0. Counters are 0. RAM contents are don't-care.
- States:
  - IDLE: on start, latch len = last_address, clear the write counter, read pointer and err, and go to FILL.
  - FILL: each di_en with di_addr <= len writes {di_re,di_im} at di_addr and increments wcnt.
    - di_en with di_addr > len is dropped and sets err; wcnt is unchanged.
    - The write that makes wcnt == len+1 moves the state to DRAIN at the same edge.
  - DRAIN: read pointer rptr runs 0..len through a 1-cycle synchronous RAM read, with a registered output stage plus a one-entry skid register.
    - The first read is issued the cycle after entering DRAIN.
    - do_valid first rises 2 clocks after the edge that accepted the final write.
    - With do_ready held high, throughput is one sample per clock with no bubbles.
    - do_re, do_im, do_index and do_last stay stable while do_valid && !do_ready.
    - The handshake on the sample with do_last set returns the state to IDLE; do_valid is 0 the next cycle.
- di_en in IDLE or DRAIN: sample dropped, err set.
- start in FILL or DRAIN (abort): pipeline flushed, do_valid forced to 0 next cycle, new len latched, state FILL, err cleared.
- start and di_en in the same cycle: start wins; the sample is dropped without setting err.
- last_address = 0 (N=1): one write leads to one output with do_last=1.
- Duplicate write addresses overwrite the entry and still count; this is not detected.
- busy = (state != IDLE).
- No arithmetic on the data; samples pass bit-exact. RAM word width is 2*WIDTH, stored as {re,im}.

Decomposition:
- Shared package (dft_pkg): state encoding localparams S_IDLE/S_FILL/S_DRAIN, the default WIDTH=18 and AW=11, and the constant MAX_POINTS=2048.
- Sub-module reorder_ram: single-clock simple dual-port RAM with one write port, one synchronous read port, parameters DW and AW, and no reset on the array.
- The FSM, counters and output skid logic stay in dft_out_reorder.

Test Plan:
- 12-point symbol: start with last_address=11, then di_en on 12 consecutive cycles with addr 0,4,8,1,5,9,2,6,10,3,7,11 and data re=addr+100. With do_ready=1, require do_re=100..111 with do_index 0..11 on 12 consecutive cycles, do_last only at index 11, do_valid rising 2 clocks after the last write, busy low after the final handshake, err=0.
- Backpressure on a 12-point symbol: toggle do_ready every other cycle. Outputs stay stable while stalled; the order is unchanged; exactly 12 handshakes occur.
- Out-of-range address: last_address=5, one write to addr 9 among 6 valid writes. err=1; the 6 valid samples still drain in order. The next start clears err.
- Stray strobe: di_en pulse while IDLE sets err=1, then DRAIN starts with the following valid symbol.
- Abort: start mid-DRAIN after 3 of 12 outputs. do_valid drops the next cycle, state is FILL, and the new 6-point symbol drains correctly.
- Async reset during DRAIN: rst_n low mid-cycle clears do_valid and busy immediately. After release, with no start pulse, no output appears.
- 1200-point symbol (24·50 pattern) with random do_ready: all 1200 samples are delivered in order and do_last appears exactly once.

Source files
------------

// File: rtl/dft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dft_pkg
//  Description : Shared constants and state encoding for the DFT output
//                reorder buffer (digit-reversed capture, natural-order drain).
//  Contents    : DEF_WIDTH  - default real/imag component width
//                DEF_AW     - default address width (RAM depth 2^AW)
//                MAX_POINTS - largest supported DFT size
//                S_IDLE / S_FILL / S_DRAIN - state codes, state_t enum
//  Revision    : 1.0 - initial release
// ============================================================================
package dft_pkg;

  localparam int DEF_WIDTH  = 18;
  localparam int DEF_AW     = 11;
  localparam int MAX_POINTS = 2048;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_FILL  = S_FILL,
    ST_DRAIN = S_DRAIN
  } state_t;

endpackage
`default_nettype wire

// File: rtl/reorder_ram.sv
`default_nettype none
// ============================================================================
//  Module      : reorder_ram
//  Description : Single-clock simple dual-port RAM. One write port, one
//                synchronous read port (data valid the cycle after re).
//                The array carries no reset.
//  Ports       : clk   - clock
//                we    - write enable
//                waddr - write address
//                wdata - write data
//                re    - read enable
//                raddr - read address
//                rdata - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module reorder_ram #(
  parameter int DW = 36,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/dft_out_reorder.sv
`default_nettype none
// ============================================================================
//  Module      : dft_out_reorder
//  Description : Captures one DFT symbol delivered in digit-reversed order at
//                explicit write addresses, then streams it out in natural
//                order 0..N-1 over a valid/ready interface.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                start, last_address   - arm capture, N-1 sampled on start
//                di_en/di_addr/di_re/di_im - DFT core sample + address
//                do_re/do_im/do_index/do_last/do_valid - output sample
//                do_ready              - downstream accept
//                busy                  - FILL or DRAIN in progress
//                err                   - sticky error, cleared by start
//  Revision    : 1.0 - initial release
// ============================================================================
module dft_out_reorder
  import dft_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    last_address,
  input  logic             di_en,
  input  logic [AW-1:0]    di_addr,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im,
  output logic             do_valid,
  input  logic             do_ready,
  output logic [AW-1:0]    do_index,
  output logic             do_last,
  output logic             busy,
  output logic             err
);

  localparam int DW = 2 * WIDTH;

  state_t state, state_next;

  logic [AW-1:0] len;
  logic [AW:0]   wcnt;
  logic [AW:0]   rptr;

  // Control decoded from state and inputs
  logic wr_en;
  logic wr_bad;
  logic rd_issue;
  logic rd_more;
  logic out_adv;
  logic skid_next;
  logic hs_last;

  // RAM read stage: rdata is valid when rd_v is set, tagged with rd_idx
  logic [DW-1:0] rdata;
  logic          rd_v;
  logic [AW-1:0] rd_idx;

  // One-entry skid holding a read that returned while the output stalled
  logic          skid_v;
  logic [DW-1:0] skid_data;
  logic [AW-1:0] skid_idx;

  // Source feeding the output register: skid has priority (older sample)
  logic          src_v;
  logic [DW-1:0] src_data;
  logic [AW-1:0] src_idx;

  reorder_ram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (di_addr),
    .wdata ({di_re, di_im}),
    .re    (rd_issue),
    .raddr (rptr[AW-1:0]),
    .rdata (rdata)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    wr_bad     = 1'b0;
    rd_issue   = 1'b0;
    out_adv    = !do_valid || do_ready;
    // Skid occupancy after this edge; a read may only be issued if the skid
    // will be free to absorb its data should the output stall next cycle.
    skid_next  = (rd_v && (!out_adv || skid_v)) || (skid_v && !out_adv);
    rd_more    = (rptr <= {1'b0, len});
    hs_last    = do_valid && do_ready && do_last;
    src_v      = skid_v || rd_v;
    src_data   = skid_v ? skid_data : rdata;
    src_idx    = skid_v ? skid_idx  : rd_idx;

    // start overrides everything, including a coincident di_en (no error)
    if (start) begin
      state_next = ST_FILL;
    end else begin
      case (state)
        ST_IDLE: begin
          wr_bad = di_en;
        end
        ST_FILL: begin
          if (di_en) begin
            if (di_addr <= len) begin
              wr_en = 1'b1;
              if (wcnt == {1'b0, len}) begin
                state_next = ST_DRAIN;
              end
            end else begin
              wr_bad = 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          wr_bad   = di_en;
          rd_issue = rd_more && !skid_next;
          if (hs_last) begin
            state_next = ST_IDLE;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len       <= '0;
      wcnt      <= '0;
      rptr      <= '0;
      err       <= 1'b0;
      rd_v      <= 1'b0;
      rd_idx    <= '0;
      skid_v    <= 1'b0;
      skid_data <= '0;
      skid_idx  <= '0;
      do_valid  <= 1'b0;
      do_last   <= 1'b0;
      do_re     <= '0;
      do_im     <= '0;
      do_index  <= '0;
    end else if (start) begin
      // New symbol or abort: flush every pipeline stage
      len      <= last_address;
      wcnt     <= '0;
      rptr     <= '0;
      err      <= 1'b0;
      rd_v     <= 1'b0;
      skid_v   <= 1'b0;
      do_valid <= 1'b0;
      do_last  <= 1'b0;
    end else begin
      if (wr_en) begin
        wcnt <= wcnt + (AW+1)'(1);
      end
      if (wr_bad) begin
        err <= 1'b1;
      end
      if (rd_issue) begin
        rptr   <= rptr + (AW+1)'(1);
        rd_idx <= rptr[AW-1:0];
      end
      rd_v <= rd_issue;

      if (out_adv) begin
        do_valid <= src_v;
        if (src_v) begin
          do_re    <= src_data[DW-1:WIDTH];
          do_im    <= src_data[WIDTH-1:0];
          do_index <= src_idx;
          do_last  <= (src_idx == len);
        end else begin
          do_last  <= 1'b0;
        end
        // Skid drained into the output; a read landing now refills it
        skid_v <= skid_v && rd_v;
        if (skid_v && rd_v) begin
          skid_data <= rdata;
          skid_idx  <= rd_idx;
        end
      end else if (rd_v) begin
        skid_v    <= 1'b1;
        skid_data <= rdata;
        skid_idx  <= rd_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dft_out_reorder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dft_out_reorder
//  Description : Self-checking bench for dft_out_reorder. Expected samples
//                are queued in natural order when a symbol is written and
//                popped on every output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dft_out_reorder;

  typedef struct {
    logic [17:0] re;
    logic [17:0] im;
    logic [10:0] idx;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [10:0] last_address = '0;
  logic        di_en = 1'b0;
  logic [10:0] di_addr = '0;
  logic [17:0] di_re = '0;
  logic [17:0] di_im = '0;
  logic [17:0] do_re;
  logic [17:0] do_im;
  logic        do_valid;
  logic        do_ready = 1'b1;
  logic [10:0] do_index;
  logic        do_last;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;
  int hs_count = 0;
  int last_count = 0;
  int rdy_mode = 0;
  bit stab_en  = 1'b0;

  exp_t sb[$];
  exp_t mon_e;
  logic [17:0] re_tab [0:2047];
  logic [17:0] im_tab [0:2047];

  bit          held_v = 1'b0;
  logic [17:0] h_re, h_im;
  logic [10:0] h_idx;
  logic        h_last;

  dft_out_reorder u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .last_address (last_address),
    .di_en        (di_en),
    .di_addr      (di_addr),
    .di_re        (di_re),
    .di_im        (di_im),
    .do_re        (do_re),
    .do_im        (do_im),
    .do_valid     (do_valid),
    .do_ready     (do_ready),
    .do_index     (do_index),
    .do_last      (do_last),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Ready generator: 0 = always ready, 1 = toggling, 2 = random
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       do_ready = 1'b1;
        1:       do_ready = ~do_ready;
        default: do_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: stall stability and scoreboard comparison
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (stab_en && held_v) begin
        check_eq("stall_valid", do_valid, 1);
        check_eq("stall_re", do_re, h_re);
        check_eq("stall_im", do_im, h_im);
        check_eq("stall_idx", do_index, h_idx);
        check_eq("stall_last", do_last, h_last);
      end
      held_v = do_valid && !do_ready;
      h_re = do_re; h_im = do_im; h_idx = do_index; h_last = do_last;
      if (do_valid && do_ready) begin
        hs_count++;
        if (do_last) last_count++;
        if (sb.size() == 0) begin
          check_eq("unexpected_out", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check_eq("out_re", do_re, mon_e.re);
          check_eq("out_im", do_im, mon_e.im);
          check_eq("out_idx", do_index, mon_e.idx);
          check_eq("out_last", do_last, mon_e.last);
        end
      end
    end
  end

  task automatic pulse_start(input int last);
    last_address = 11'(last);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Writes a p*q symbol in digit-reversed order addr = i*q + j (j outer).
  // An extra out-of-range write is inserted before position bad_pos.
  task automatic write_symbol(input int p, input int q, input int bad_pos,
                              input int bad_addr, input int base);
    int   n, k;
    exp_t e;
    n = p * q;
    for (int a = 0; a < n; a++) begin
      re_tab[a] = 18'(a + 100 + base);
      im_tab[a] = 18'($urandom);
      e.re = re_tab[a]; e.im = im_tab[a]; e.idx = 11'(a); e.last = (a == n - 1);
      sb.push_back(e);
    end
    k = 0;
    for (int j = 0; j < q; j++) begin
      for (int i = 0; i < p; i++) begin
        if (k == bad_pos) begin
          di_en = 1'b1; di_addr = 11'(bad_addr); di_re = 18'h3FFFF; di_im = 18'h3FFFF;
          @(posedge clk); #1;
        end
        di_en = 1'b1; di_addr = 11'(i * q + j);
        di_re = re_tab[i * q + j]; di_im = im_tab[i * q + j];
        @(posedge clk); #1;
        k++;
      end
    end
    di_en = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int cyc = 0;
    while ((sb.size() != 0 || busy) && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("drain_in_budget", (cyc < budget), 1);
    check_eq("drain_sb_empty", sb.size(), 0);
    check_eq("drain_busy", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int hs0, lc0, run;

    #3;
    check_eq("rst_valid", do_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_last", do_last, 0);
    check_eq("rst_re", do_re, 0);
    check_eq("rst_im", do_im, 0);
    check_eq("rst_idx", do_index, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    stab_en = 1'b1;

    // Stray strobe in IDLE
    di_en = 1'b1; di_addr = 11'd3;
    @(posedge clk); #1;
    di_en = 1'b0;
    check_eq("stray_err", err, 1);
    check_eq("stray_busy", busy, 0);

    // 12-point symbol, ready held high; start clears err
    hs0 = hs_count; lc0 = last_count;
    pulse_start(11);
    check_eq("start_clr_err", err, 0);
    check_eq("fill_busy", busy, 1);
    write_symbol(3, 4, -1, 0, 0);
    check_eq("lat0_valid", do_valid, 0);
    @(posedge clk); #1;
    check_eq("lat1_valid", do_valid, 0);
    @(posedge clk); #1;
    check_eq("lat2_valid", do_valid, 1);
    run = 0;
    while (do_valid && run < 100) begin
      run++;
      @(posedge clk); #1;
    end
    check_eq("run_len", run, 12);
    check_eq("p12_busy", busy, 0);
    check_eq("p12_err", err, 0);
    check_eq("p12_hs", hs_count - hs0, 12);
    check_eq("p12_last", last_count - lc0, 1);
    check_eq("p12_sb", sb.size(), 0);

    // Backpressure: toggling ready
    hs0 = hs_count;
    rdy_mode = 1;
    pulse_start(11);
    write_symbol(3, 4, -1, 0, 500);
    wait_drain(200);
    check_eq("bp_hs", hs_count - hs0, 12);
    rdy_mode = 0;
    @(posedge clk); #1;

    // Out-of-range address
    hs0 = hs_count;
    pulse_start(5);
    write_symbol(2, 3, 3, 9, 1000);
    check_eq("oor_err", err, 1);
    wait_drain(100);
    check_eq("oor_hs", hs_count - hs0, 6);
    check_eq("oor_err_sticky", err, 1);

    // start coincident with di_en: sample dropped without error; N=1
    hs0 = hs_count; lc0 = last_count;
    last_address = 11'd0; start = 1'b1;
    di_en = 1'b1; di_addr = 11'd0; di_re = 18'h12345; di_im = 18'h0ABCD;
    @(posedge clk); #1;
    start = 1'b0; di_en = 1'b0;
    check_eq("sd_err", err, 0);
    check_eq("sd_busy", busy, 1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("sd_no_out", do_valid, 0);
    write_symbol(1, 1, -1, 0, 2000);
    wait_drain(50);
    check_eq("n1_hs", hs_count - hs0, 1);
    check_eq("n1_last", last_count - lc0, 1);

    // Abort mid-drain after 3 outputs
    stab_en = 1'b0;
    hs0 = hs_count;
    pulse_start(11);
    write_symbol(3, 4, -1, 0, 3000);
    run = 0;
    while (hs_count - hs0 < 3 && run < 100) begin
      @(negedge clk); #1;
      run++;
    end
    check_eq("abort_reach3", hs_count - hs0, 3);
    last_address = 11'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sb.delete();
    check_eq("abort_valid", do_valid, 0);
    check_eq("abort_busy", busy, 1);
    check_eq("abort_err", err, 0);
    hs0 = hs_count;
    write_symbol(2, 3, -1, 0, 4000);
    wait_drain(100);
    check_eq("abort_hs", hs_count - hs0, 6);

    // Asynchronous reset during DRAIN
    hs0 = hs_count;
    pulse_start(11);
    write_symbol(3, 4, -1, 0, 5000);
    run = 0;
    while (hs_count - hs0 < 4 && run < 100) begin
      @(negedge clk); #1;
      run++;
    end
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", do_valid, 0);
    check_eq("arst_busy", busy, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    hs0 = hs_count;
    repeat (20) @(posedge clk);
    #1;
    check_eq("arst_no_hs", hs_count - hs0, 0);
    check_eq("arst_idle_valid", do_valid, 0);
    check_eq("arst_idle_busy", busy, 0);

    // 1200-point symbol with random ready
    stab_en = 1'b1;
    hs0 = hs_count; lc0 = last_count;
    rdy_mode = 2;
    pulse_start(1199);
    write_symbol(24, 50, -1, 0, 7);
    wait_drain(20000);
    check_eq("big_hs", hs_count - hs0, 1200);
    check_eq("big_last", last_count - lc0, 1);
    check_eq("big_err", err, 0);
    rdy_mode = 0;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
